rev_mux_arbiter: RTL

REV_MUX_ARBITER -- requirements
Module: rev_mux_arbiter

---
 rtl/rev_mux_arbiter_pkg.sv | 19 +
 rtl/rev_mux_arbiter_mux21.sv | 25 ++
 rtl/rev_mux_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rev_mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rev_arb_pkg
// Shared definitions for the two-requester packet arbiter:
//   arb_state_t      - arbiter FSM states (IDLE, GRANT0, GRANT1)
//   DEFAULT_WIDTH    - default data width of a beat
//   PKT_COUNT_WIDTH  - width of the completed-packet counter
// ---------------------------------------------------------------------------
package rev_arb_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int PKT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rev_mux_arbiter_mux21.sv
// ---------------------------------------------------------------------------
// mux21
// Single-bit 2:1 multiplexer slice, instantiated once per data bit.
// Ports:
//   ip_1        in   selected when sel = 0
//   ip_2        in   selected when sel = 1
//   sel         in   select
//   mux_out     out  selected bit
//   garbage_and out  side product of the inputs; callers leave it unused
//   garbage_xor out  side product of the inputs; callers leave it unused
// ---------------------------------------------------------------------------
module mux21 (
  input  logic ip_1,
  input  logic ip_2,
  input  logic sel,
  output logic mux_out,
  output logic garbage_and,
  output logic garbage_xor
);

  assign mux_out     = sel ? ip_2 : ip_1;
  assign garbage_and = ip_1 & ip_2;
  assign garbage_xor = ip_1 ^ ip_2;

endmodule

// File: rtl/rev_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rev_mux_arbiter
// Packet-granular arbiter between two requesters feeding one registered
// output slot. A grant is held for a whole packet; ties in IDLE go to the
// requester that was not served last. Data is steered bit-by-bit through
// mux21 slices into a one-beat output register with full throughput.
// Ports:
//   clk                       in   rising-edge clock
//   rst_n                     in   synchronous active-low reset
//   req0_valid / req1_valid   in   requester offers a beat
//   req0_data  / req1_data    in   requester beat data [WIDTH]
//   req0_last  / req1_last    in   beat ends requester's packet
//   req0_ready / req1_ready   out  beat accepted this cycle
//   out_valid                 out  output register holds a beat
//   out_ready                 in   sink accepts output beat
//   out_data                  out  output beat data [WIDTH]
//   out_src                   out  source of output beat (0=req0, 1=req1)
//   out_last                  out  output beat ends a packet
//   pkt_count                 out  packets completed at the output [16]
// ---------------------------------------------------------------------------
module rev_mux_arbiter
  import rev_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [WIDTH-1:0]           req0_data,
  input  logic                       req0_last,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [WIDTH-1:0]           req1_data,
  input  logic                       req1_last,
  output logic                       req1_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_src,
  output logic                       out_last,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

  arb_state_t                 state;
  logic                       last_served;
  logic                       slot_free;
  logic                       xfer0;
  logic                       xfer1;
  logic                       xfer;
  logic                       xfer_last;
  logic                       sel_grant1;
  logic                       count_inc;
  logic [PKT_COUNT_WIDTH-1:0] pkt_count_q;
  logic [WIDTH-1:0]           mux_data;
  logic [WIDTH-1:0]           unused_garbage_and;
  logic [WIDTH-1:0]           unused_garbage_xor;

  // The output slot can take a new beat when empty or being drained now.
  // Gating with rst_n keeps both readies low while reset is asserted.
  assign slot_free  = !out_valid || out_ready;
  assign req0_ready = rst_n && (state == GRANT0) && slot_free;
  assign req1_ready = rst_n && (state == GRANT1) && slot_free;

  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign xfer       = xfer0 || xfer1;
  assign xfer_last  = xfer0 ? req0_last : req1_last;
  assign sel_grant1 = (state == GRANT1);
  assign count_inc  = out_valid && out_ready && out_last;
  assign pkt_count  = pkt_count_q;

  // One mux21 per data bit; their side outputs are deliberately unused.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux21 u_mux (
      .ip_1        (req0_data[i]),
      .ip_2        (req1_data[i]),
      .sel         (sel_grant1),
      .mux_out     (mux_data[i]),
      .garbage_and (unused_garbage_and[i]),
      .garbage_xor (unused_garbage_xor[i])
    );
  end

  // Arbiter FSM: IDLE picks a winner (alternating on ties), GRANTn holds
  // until the requester's last beat transfers, then one IDLE turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            state <= last_served ? GRANT0 : GRANT1;
          end else if (req0_valid) begin
            state <= GRANT0;
          end else if (req1_valid) begin
            state <= GRANT1;
          end
        end
        GRANT0: begin
          if (xfer0 && req0_last) begin
            state       <= IDLE;
            last_served <= 1'b0;
          end
        end
        GRANT1: begin
          if (xfer1 && req1_last) begin
            state       <= IDLE;
            last_served <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output slot: a transfer always loads (even while draining, giving one
  // beat per cycle); otherwise a drain empties it. Held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= sel_grant1;
      out_last  <= xfer_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Completed-packet counter; wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_q + {{(PKT_COUNT_WIDTH-1){1'b0}}, count_inc};
    end
  end

endmodule
